// File: rtl/multiword_add_ctrl.sv
// Wide add/subtract sequencer: runs one external N-bit adder slice over WORDS
// cycles, LS word first, feeding the registered carry-out back as carry-in.
module multiword_add_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow,
  output logic [N-1:0]         add_x,
  output logic [N-1:0]         add_y,
  output logic                 add_cin,
  input  logic [N-1:0]         add_s,
  input  logic                 add_cout
);

  localparam int W  = N * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    s_top;
  logic [W-1:0]    acc_next;
  logic            last_word;

  // The adder result enters the top word while older words shift down, so
  // after WORDS steps the LS word has reached bit 0.
  always_comb begin
    s_top            = '0;
    s_top[W-1 -: N]  = add_s;
    acc_next         = (acc_q >> N) | s_top;
    last_word        = (cnt_q == CW'(WORDS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_x   = a_sh_q[N-1:0];
        add_y   = b_sh_q[N-1:0];
        add_cin = carry_q;
        a_sh_d  = a_sh_q >> N;
        b_sh_d  = b_sh_q >> N;
        acc_d   = acc_next;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_word) begin
          state_d = DONE;
          sum_d   = acc_next;
          cout_d  = add_cout;
          // Sign bits of the MS word operands are the full-width sign bits.
          ovf_d   = (a_sh_q[N-1] == b_sh_q[N-1]) && (add_s[N-1] != a_sh_q[N-1]);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
